mips_muldiv: RTL and testbench
==============================

MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 SHALL have no parameters; width fixed at 32, iteration count fixed at 32.
REQ-002 CLK  in  1  single clock, all state on rising edge.
REQ-003 RST_N  in  1  asynchronous, active-low reset.
REQ-004 START  in  1  request pulse, sampled on rising edge.
REQ-005 MDOP  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 ReadData1  in  32  rs operand (dividend / multiplicand; MTHI/MTLO source).
REQ-007 ReadData2  in  32  rt operand (divisor / multiplier).
REQ-008 HIWrite  in  1  MTHI: load HI from ReadData1.
REQ-009 LOWrite  in  1  MTLO: load LO from ReadData1.
REQ-010 BUSY  out  1  operation in progress; pipeline stalls MFHI/MFLO/new MULT/DIV.
REQ-011 DONE  out  1  one-cycle completion pulse.
REQ-012 DIVZERO  out  1  one-cycle pulse with DONE when DIV/DIVU divisor is zero.
REQ-013 HI  out  32  HI register (product upper word / remainder).
REQ-014 LO  out  32  LO register (product lower word / quotient).

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, FIX; transitions only on CLK rising edge.
REQ-016 Edge E0 with IDLE, START=1, HIWrite=LOWrite=0: latch operand magnitudes (signed ops) or raw values (unsigned ops) plus result signs; go MUL or DIV; iteration counter=0.
REQ-017 MUL: radix-2 shift-add, one bit per edge, 32 edges (E1..E32), then FIX.
REQ-018 DIV: restoring shift-subtract on magnitudes, one quotient bit per edge, 32 edges, then FIX.
REQ-019 FIX (edge E33): apply sign correction, write HI/LO, return to IDLE; DONE=1 for the cycle after E33 only.
REQ-020 BUSY SHALL be 1 in every cycle after E0 up to and including E33's edge; 0 in the DONE cycle, so a new START is accepted in the DONE cycle.
REQ-021 Signed MULT: 64-bit product negated when operand signs differ; MULTU: unsigned 64-bit product; HI=[63:32], LO=[31:0].
REQ-022 Signed DIV: quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs); LO=quotient, HI=remainder.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000 (32-bit wrap, no trap).
REQ-024 DIV/DIVU with ReadData2=0 at E0: no iteration; at E1 return to IDLE, HI/LO unchanged, DONE=DIVZERO=1 for the cycle after E1.
REQ-025 START while BUSY SHALL be ignored; operands of the running operation remain unchanged.
REQ-026 HIWrite/LOWrite in IDLE: write ReadData1 to HI/LO at that edge; both may assert together; START asserted in the same cycle SHALL be ignored.
REQ-027 HIWrite/LOWrite while BUSY SHALL be ignored.
REQ-028 HI/LO SHALL change only at FIX, on HIWrite/LOWrite, or on reset; intermediate iteration state is held in separate registers.

Reset
REQ-029 RST_N low SHALL immediately force state IDLE, counter 0, BUSY=0, DONE=0, DIVZERO=0, HI=0, LO=0, aborting any operation.
REQ-030 First START after RST_N deassertion SHALL complete with normal 33-edge latency.

Structure
REQ-031 Shared package mips_pkg SHALL hold MDOP codes, FSM state encodings and the iteration-count constant.
REQ-032 One combinational sub-module mips_muldiv_step (single shift-add / shift-subtract iteration) SHALL be instantiated; FSM, counter and sign fix-up stay in mips_muldiv.

Verification
REQ-033 MULT 0xFFFFFFFF x 0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; DONE exactly in cycle after E33.
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; back-to-back START in DONE cycle accepted.
REQ-035 DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-036 DIV 5/0 -> DONE=DIVZERO=1 in cycle after E1, HI/LO unchanged; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 START during BUSY ignored; RST_N low at iteration 10 -> BUSY, DONE, HI, LO = 0 immediately, next START completes correctly.
REQ-038 HIWrite with ReadData1=0x12345678 in IDLE -> HI=0x12345678 next cycle; same while BUSY -> HI unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MDOP codes, FSM states and iteration constants for the mult/div unit
package mips_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } mdop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } md_state_e;

    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 5;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

endpackage

// File: rtl/mips_muldiv_if.sv
// rtl/mips_muldiv_if.sv - pipeline-side handshake and HI/LO bus of the mult/div unit
interface mips_muldiv_if;
    logic        START;
    logic [1:0]  MDOP;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        HIWrite;
    logic        LOWrite;
    logic        BUSY;
    logic        DONE;
    logic        DIVZERO;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output START, MDOP, ReadData1, ReadData2, HIWrite, LOWrite,
        input  BUSY, DONE, DIVZERO, HI, LO
    );

    modport slave (
        input  START, MDOP, ReadData1, ReadData2, HIWrite, LOWrite,
        output BUSY, DONE, DIVZERO, HI, LO
    );
endinterface

// File: rtl/mips_muldiv_step.sv
// rtl/mips_muldiv_step.sv - one radix-2 shift-add (multiply) or restoring shift-subtract (divide) iteration
module mips_muldiv_step (
    input  logic        i_is_div,
    input  logic [63:0] i_acc,
    input  logic [31:0] i_operand,
    output logic [63:0] o_acc
);
    logic [32:0] w_sum;
    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    // Divide:   acc = {partial remainder, remaining dividend / growing quotient}, shifted left.
    assign w_sum   = {1'b0, i_acc[63:32]} + {1'b0, i_operand};
    assign w_shift = i_acc[63:31];
    assign w_diff  = w_shift - {1'b0, i_operand};

    always_comb begin
        o_acc = i_acc;
        if (i_is_div) begin
            if (!w_diff[32]) begin
                o_acc = {w_diff[31:0], i_acc[30:0], 1'b1};
            end else begin
                o_acc = {w_shift[31:0], i_acc[30:0], 1'b0};
            end
        end else begin
            if (i_acc[0]) begin
                o_acc = {w_sum, i_acc[31:1]};
            end else begin
                o_acc = {1'b0, i_acc[63:1]};
            end
        end
    end
endmodule

// File: rtl/mips_muldiv.sv
// rtl/mips_muldiv.sv - 32-cycle iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mips_muldiv
    import mips_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_N,
    mips_muldiv_if.slave  bus
);
    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_divzero;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [63:0]      r_acc;
    logic [31:0]      r_operand;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz_pend;

    logic             w_signed;
    logic             w_is_div;
    logic [31:0]      w_a_mag;
    logic [31:0]      w_b_mag;
    logic             w_b_zero;
    logic [63:0]      w_step_acc;
    logic [63:0]      w_prod;
    logic [31:0]      w_quo;
    logic [31:0]      w_rem;

    assign w_signed = (bus.MDOP == MD_MULT) || (bus.MDOP == MD_DIV);
    assign w_is_div = (bus.MDOP == MD_DIV)  || (bus.MDOP == MD_DIVU);
    assign w_a_mag  = (w_signed && bus.ReadData1[31]) ? -bus.ReadData1 : bus.ReadData1;
    assign w_b_mag  = (w_signed && bus.ReadData2[31]) ? -bus.ReadData2 : bus.ReadData2;
    assign w_b_zero = (bus.ReadData2 == 32'd0);

    mips_muldiv_step u_step (
        .i_is_div  (r_state == ST_DIV),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_step_acc)
    );

    // Sign fix-up on the unsigned magnitude result; 0x80000000 / -1 wraps naturally.
    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[31:0]  : r_acc[31:0];
    assign w_rem  = r_neg_r ? -r_acc[63:32] : r_acc[63:32];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz_pend <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.HIWrite || bus.LOWrite) begin
                        if (bus.HIWrite) r_hi <= bus.ReadData1;
                        if (bus.LOWrite) r_lo <= bus.ReadData1;
                    end else if (bus.START) begin
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_is_div  <= w_is_div;
                        r_neg_q   <= w_signed && (bus.ReadData1[31] ^ bus.ReadData2[31]);
                        r_neg_r   <= w_signed && bus.ReadData1[31];
                        r_dz_pend <= w_is_div && w_b_zero;
                        if (w_is_div) begin
                            r_operand <= w_b_mag;
                            r_acc     <= {32'd0, w_a_mag};
                            r_state   <= w_b_zero ? ST_FIX : ST_DIV;
                        end else begin
                            r_operand <= w_a_mag;
                            r_acc     <= {32'd0, w_b_mag};
                            r_state   <= ST_MUL;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    r_acc <= w_step_acc;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_cnt   <= '0;
                    if (r_dz_pend) begin
                        r_divzero <= 1'b1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.BUSY    = r_busy;
    assign bus.DONE    = r_done;
    assign bus.DIVZERO = r_divzero;
    assign bus.HI      = r_hi;
    assign bus.LO      = r_lo;
endmodule

// File: tb/tb_mips_muldiv.sv
// tb/tb_mips_muldiv.sv - directed self-checking bench for mips_muldiv
module tb_mips_muldiv;
    import mips_pkg::*;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    mips_muldiv_if bus();

    mips_muldiv dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Drives the request in the current cycle; returns #1 after the accepting edge (E0).
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.START     = 1'b1;
        bus.MDOP      = op;
        bus.ReadData1 = a;
        bus.ReadData2 = b;
        @(posedge CLK); #1;
        bus.START     = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.DONE !== 1'b1 && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        @(negedge CLK);
        launch(op, a, b);
        wait_done(n);
    endtask

    initial begin
        bus.START = 1'b0; bus.MDOP = 2'b00; bus.ReadData1 = '0; bus.ReadData2 = '0;
        bus.HIWrite = 1'b0; bus.LOWrite = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_divzero", 32'(bus.DIVZERO), 32'd0);
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        @(negedge CLK); RST_N = 1'b1;

        // MULT -1 x 2
        run_op(MD_MULT, 32'hFFFFFFFF, 32'h00000002, lat);
        chk("mult_lat", 32'(lat), 32'd33);
        chk("mult_hi", bus.HI, 32'hFFFFFFFF);
        chk("mult_lo", bus.LO, 32'hFFFFFFFE);
        chk("mult_busy_in_done", 32'(bus.BUSY), 32'd0);
        chk("mult_divzero", 32'(bus.DIVZERO), 32'd0);
        @(posedge CLK); #1;
        chk("mult_done_one_cycle", 32'(bus.DONE), 32'd0);

        // MULTU max x max, then DIVU 7/2 launched in the DONE cycle
        run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        chk("multu_lat", 32'(lat), 32'd33);
        chk("multu_hi", bus.HI, 32'hFFFFFFFE);
        chk("multu_lo", bus.LO, 32'h00000001);
        launch(MD_DIVU, 32'd7, 32'd2);
        chk("b2b_busy", 32'(bus.BUSY), 32'd1);
        wait_done(lat);
        chk("divu_lat", 32'(lat), 32'd33);
        chk("divu_lo", bus.LO, 32'd3);
        chk("divu_hi", bus.HI, 32'd1);

        // DIV -7 / 2
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, lat);
        chk("div_lat", 32'(lat), 32'd33);
        chk("div_lo", bus.LO, 32'hFFFFFFFD);
        chk("div_hi", bus.HI, 32'hFFFFFFFF);

        // DIV 5 / 0
        run_op(MD_DIV, 32'd5, 32'd0, lat);
        chk("dz_lat", 32'(lat), 32'd1);
        chk("dz_flag", 32'(bus.DIVZERO), 32'd1);
        chk("dz_hi", bus.HI, 32'hFFFFFFFF);
        chk("dz_lo", bus.LO, 32'hFFFFFFFD);

        // DIV 0x80000000 / -1
        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
        chk("ovf_lo", bus.LO, 32'h80000000);
        chk("ovf_hi", bus.HI, 32'h00000000);

        // HIWrite with START in IDLE: write wins, START ignored
        @(negedge CLK);
        bus.HIWrite = 1'b1; bus.START = 1'b1; bus.MDOP = MD_MULTU;
        bus.ReadData1 = 32'h12345678; bus.ReadData2 = 32'd3;
        @(posedge CLK); #1;
        bus.HIWrite = 1'b0; bus.START = 1'b0;
        chk("mthi_hi", bus.HI, 32'h12345678);
        chk("mthi_lo_kept", bus.LO, 32'h80000000);
        chk("mthi_no_start", 32'(bus.BUSY), 32'd0);
        @(negedge CLK);
        bus.LOWrite = 1'b1; bus.ReadData1 = 32'hCAFEF00D;
        @(posedge CLK); #1;
        bus.LOWrite = 1'b0;
        chk("mtlo_lo", bus.LO, 32'hCAFEF00D);

        // MULTU 3 x 5 with START and HIWrite injected while busy
        @(negedge CLK);
        launch(MD_MULTU, 32'd3, 32'd5);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        bus.START = 1'b1; bus.MDOP = MD_DIVU; bus.ReadData1 = 32'd100; bus.ReadData2 = 32'd7;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        @(negedge CLK);
        bus.HIWrite = 1'b1; bus.ReadData1 = 32'hDEADBEEF;
        @(posedge CLK); #1;
        bus.HIWrite = 1'b0;
        chk("busy_mthi_ignored", bus.HI, 32'h12345678);
        wait_done(lat);
        chk("busy_start_lat", 32'(lat + 4), 32'd33);
        chk("busy_start_hi", bus.HI, 32'd0);
        chk("busy_start_lo", bus.LO, 32'd15);

        // Reset at iteration 10, then a fresh MULT 7 x -3
        @(negedge CLK);
        launch(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.BUSY), 32'd0);
        chk("abort_done", 32'(bus.DONE), 32'd0);
        chk("abort_hi", bus.HI, 32'd0);
        chk("abort_lo", bus.LO, 32'd0);
        @(negedge CLK); RST_N = 1'b1;
        run_op(MD_MULT, 32'd7, 32'hFFFFFFFD, lat);
        chk("post_rst_lat", 32'(lat), 32'd33);
        chk("post_rst_hi", bus.HI, 32'hFFFFFFFF);
        chk("post_rst_lo", bus.LO, 32'hFFFFFFEB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
